mult_seq_signed: RTL and testbench
==================================

# mult_seq_signed

Parametrised sequential signed (two's-complement) add-shift multiplier for the lab datapath. It generalises the fixed 8-bit switch-driven multiplier to any operand width, and it replaces button-driven Run/ClearA_LoadB control with valid/ready handshakes on both operands and result. It sits between an operand source (switch/synchroniser logic or a bus master) and a result consumer (hex display registers or a downstream block), and processes one multiplication at a time.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- Clk  input  1  system clock; all state is updated on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start_Valid  input  1  operand pair is presented.
- Start_Ready  output  1  block accepts operands; high only in IDLE.
- Multiplicand  input  WIDTH  signed operand S; sampled on the Start handshake.
- Multiplier  input  WIDTH  signed operand M; sampled on the Start handshake.
- Done_Valid  output  1  Product is valid; high only in DONE.
- Done_Ready  input  1  consumer accepts Product.
- Product  output  2*WIDTH  signed product; equals {A,B}.
- Busy  output  1  high in CALC or DONE.

## Operation
- Registers:
  - S (WIDTH), the multiplicand.
  - A (WIDTH), the upper product half.
  - B (WIDTH), the multiplier, becoming the lower product half.
  - X (1), the sign-extension bit.
  - Count ($clog2(WIDTH) bits).
  - State, one of IDLE, CALC or DONE.
- IDLE:
  - Start_Ready=1.
  - On Start_Valid&&Start_Ready: S<=Multiplicand, B<=Multiplier, A<=0, X<=0, Count<=0, go to CALC.
- CALC: one iteration per cycle.
  - The sum is WIDTH+1 bits: {X,A} + ({S[W-1],S} if B[0]).
  - When Count==WIDTH-1 and B[0]=1, subtract instead: {X,A} + ~{S[W-1],S} + 1.
  - Shift arithmetically right by one: X<=sum[W], A<=sum[W:1], B<={sum[0],B[W-1:1]}, Count<=Count+1.
  - After the iteration with Count==WIDTH-1, go to DONE.
- DONE:
  - Done_Valid=1, and A, B and Product hold their values.
  - When Done_Ready=1, go to IDLE; the registers keep their contents until the next accept.
- Start_Valid is ignored outside IDLE. Multiplicand and Multiplier are ignored outside the accept cycle.
- Reset asserted at any time (including mid-CALC or in DONE):
  - State=IDLE; A, B, S, X and Count are all 0.
  - Start_Ready=1, Done_Valid=0, Busy=0, Product=0.
  - The in-flight operation is discarded with no output.
- The result is exact for all operand pairs, including (-2^(W-1))×(-2^(W-1)) = 2^(2W-2).

## Timing
- Start is accepted at rising edge E0. Done_Valid rises after edge E0+WIDTH and is seen in the cycle following that edge.
- Done_Valid stays high until the edge at which Done_Ready=1 is sampled. Product is stable for that whole time.
- The earliest next accept is edge E0+WIDTH+2, since Start_Ready returns after the DONE→IDLE edge. Minimum throughput is one product per WIDTH+2 cycles.
- All outputs are registered or decoded from state only; there are no combinational paths from input to output.
- Reset deassertion is synchronised externally by the codebase's sync cells. The block itself only requires async assert.

## Configuration
- MULT_DBG_EN defined:
  - Adds the output ports Aval (WIDTH), Bval (WIDTH), Xval (1) and Cnt ($clog2(WIDTH)). They drive A, B, X and Count directly for simulation and for hex display of intermediate state.
- MULT_DBG_EN undefined:
  - These ports and their logic are absent. The core behaviour is identical.

## Test plan
- WIDTH=8, accept 7 × -3, Done_Ready=1 → Done_Valid rises exactly 8 cycles after the accept edge, Product=0xFFEB, IDLE one cycle later.
- WIDTH=8, cases: -128 × -128 → 0x4000; -128 × 127 → 0xC080; 0 × -1 → 0x0000; -1 × -1 → 0x0001.
- Backpressure: hold Done_Ready=0 for 20 cycles → Done_Valid and Product stay constant, Start_Ready=0, and Start_Valid pulses with new operands are ignored. Release → the next accept is possible on the following cycle.
- Reset mid-operation: assert Reset (drive low) at iteration 4 of 8 → all outputs at their reset values immediately (asynchronous). After release, a new 3 × 5 gives 0x000F with no stale data.
- WIDTH=4 and WIDTH=16 random signed operands (1000 each) against a reference model → all products match, and latency is WIDTH cycles in each case.
- With MULT_DBG_EN, WIDTH=8, 2 × 3 → Cnt steps 0..7, and Bval/Aval after the final shift are 0x06/0x00.

Source files
------------

// File: rtl/mult_seq_signed.sv
// rtl/mult_seq_signed.sv - sequential signed add-shift multiplier with valid/ready handshakes
// Optional debug ports (Aval, Bval, Xval, Cnt) are enabled by defining MULT_DBG_EN.
module mult_seq_signed #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start_Valid,
  output logic                 Start_Ready,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic                 Done_Valid,
  input  logic                 Done_Ready,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy
`ifdef MULT_DBG_EN
  ,
  output logic [WIDTH-1:0]         Aval,
  output logic [WIDTH-1:0]         Bval,
  output logic                     Xval,
  output logic [$clog2(WIDTH)-1:0] Cnt
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             x_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   ext_s;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;
  logic             last_iter;

  // The multiplier's sign bit carries negative weight, so the final
  // partial product is subtracted rather than added.
  always_comb begin
    ext_s     = {s_reg[WIDTH-1], s_reg};
    last_iter = (count == CW'(WIDTH - 1));
    addend    = '0;
    if (b_reg[0]) begin
      if (last_iter) begin
        addend = ~ext_s + (WIDTH+1)'(1);
      end else begin
        addend = ext_s;
      end
    end
    sum = {x_reg, a_reg} + addend;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      s_reg <= '0;
      a_reg <= '0;
      b_reg <= '0;
      x_reg <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start_Valid) begin
            s_reg <= Multiplicand;
            b_reg <= Multiplier;
            a_reg <= '0;
            x_reg <= 1'b0;
            count <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          x_reg <= sum[WIDTH];
          a_reg <= sum[WIDTH:1];
          b_reg <= {sum[0], b_reg[WIDTH-1:1]};
          count <= count + CW'(1);
          if (last_iter) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (Done_Ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Start_Ready = (state == IDLE);
  assign Done_Valid  = (state == DONE);
  assign Busy        = (state == CALC) || (state == DONE);
  assign Product     = {a_reg, b_reg};

`ifdef MULT_DBG_EN
  assign Aval = a_reg;
  assign Bval = b_reg;
  assign Xval = x_reg;
  assign Cnt  = count;
`endif

endmodule

// File: tb/tb_mult_seq_signed.sv
// tb/tb_mult_seq_signed.sv - self-checking bench for mult_seq_signed at WIDTH 4, 8 and 16
// Debug-port checks are compiled when MULT_DBG_EN is defined.
module tb_mult_seq_signed;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        sv [3];
  logic        dr [3];
  logic        sr [3];
  logic        dv [3];
  logic        busy [3];
  logic [31:0] prod [3];
  logic [31:0] mc, mp;

  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

`ifdef MULT_DBG_EN
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        x4, x8, x16;
  logic [1:0]  c4;
  logic [2:0]  c8;
  logic [3:0]  c16;
`endif

  mult_seq_signed #(.WIDTH(4)) u_m4 (
    .Clk(Clk), .Reset(Reset), .Start_Valid(sv[0]), .Start_Ready(sr[0]),
    .Multiplicand(mc[3:0]), .Multiplier(mp[3:0]), .Done_Valid(dv[0]),
    .Done_Ready(dr[0]), .Product(p4), .Busy(busy[0])
`ifdef MULT_DBG_EN
    , .Aval(a4), .Bval(b4), .Xval(x4), .Cnt(c4)
`endif
  );

  mult_seq_signed #(.WIDTH(8)) u_m8 (
    .Clk(Clk), .Reset(Reset), .Start_Valid(sv[1]), .Start_Ready(sr[1]),
    .Multiplicand(mc[7:0]), .Multiplier(mp[7:0]), .Done_Valid(dv[1]),
    .Done_Ready(dr[1]), .Product(p8), .Busy(busy[1])
`ifdef MULT_DBG_EN
    , .Aval(a8), .Bval(b8), .Xval(x8), .Cnt(c8)
`endif
  );

  mult_seq_signed #(.WIDTH(16)) u_m16 (
    .Clk(Clk), .Reset(Reset), .Start_Valid(sv[2]), .Start_Ready(sr[2]),
    .Multiplicand(mc[15:0]), .Multiplier(mp[15:0]), .Done_Valid(dv[2]),
    .Done_Ready(dr[2]), .Product(p16), .Busy(busy[2])
`ifdef MULT_DBG_EN
    , .Aval(a16), .Bval(b16), .Xval(x16), .Cnt(c16)
`endif
  );

  assign prod[0] = {24'd0, p4};
  assign prod[1] = {16'd0, p8};
  assign prod[2] = p16;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: interpret both operands as w-bit two's complement and multiply.
  function automatic logic [31:0] ref_mult(input int w, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, pm;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    pm = (longint'(1) << (2 * w)) - 1;
    return 32'((sa * sb) & pm);
  endfunction

  task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!sr[k] && n < 64) begin
      @(posedge Clk); #1; n++;
    end
    chk("start_ready_before_accept", {31'd0, sr[k]}, 32'd1);
    sv[k] = 1'b1; mc = a; mp = b;
    @(posedge Clk); #1;
    sv[k] = 1'b0; mc = $urandom; mp = $urandom;
  endtask

  task automatic wait_done(input int k, input int w);
    int n;
    n = 0;
    do begin
      @(posedge Clk); #1; n++;
    end while (!dv[k] && n < 64);
    chk("latency", n, w);
  endtask

  task automatic finish_op(input int k);
    dr[k] = 1'b1;
    @(posedge Clk); #1;
    dr[k] = 1'b0;
    chk("idle_after_done", {31'd0, sr[k]}, 32'd1);
  endtask

  task automatic do_mult(input int k, input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] p);
    start_op(k, a, b);
    wait_done(k, w);
    p = prod[k];
    finish_op(k);
  endtask

  vec_t        vecs [7];
  logic [31:0] p, ra, rb;
  logic [31:0] hold_p;

  initial begin
    for (int i = 0; i < 3; i++) begin sv[i] = 1'b0; dr[i] = 1'b0; end
    mc = '0; mp = '0;

    vecs[0] = '{8'h07, 8'hFD, 16'hFFEB};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h80, 8'h7F, 16'hC080};
    vecs[3] = '{8'h00, 8'hFF, 16'h0000};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{8'h03, 8'h05, 16'h000F};
    vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};

    #12;
    chk("reset_start_ready", {31'd0, sr[1]}, 32'd1);
    chk("reset_done_valid", {31'd0, dv[1]}, 32'd0);
    chk("reset_busy", {31'd0, busy[1]}, 32'd0);
    chk("reset_product", prod[1], 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    // Directed WIDTH=8 table
    for (int i = 0; i < 7; i++) begin
      do_mult(1, 8, {24'd0, vecs[i].a}, {24'd0, vecs[i].b}, p);
      chk($sformatf("vec%0d_product", i), p, {16'd0, vecs[i].exp});
    end

    // Backpressure: result held while the consumer stalls, new starts ignored
    start_op(1, 32'h05, 32'hF9);
    wait_done(1, 8);
    hold_p = prod[1];
    chk("bp_product", hold_p, 32'h0000FFDD);
    for (int c = 0; c < 20; c++) begin
      sv[1] = c[0]; mc = $urandom; mp = $urandom;
      @(posedge Clk); #1;
      chk("bp_done_valid", {31'd0, dv[1]}, 32'd1);
      chk("bp_product_hold", prod[1], hold_p);
      chk("bp_start_ready", {31'd0, sr[1]}, 32'd0);
    end
    sv[1] = 1'b0;
    finish_op(1);
    do_mult(1, 8, 32'h03, 32'h05, p);
    chk("bp_next_product", p, 32'h0000000F);

    // Asynchronous reset in the middle of a calculation
    start_op(1, 32'h7B, 32'hA5);
    repeat (4) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("midrst_start_ready", {31'd0, sr[1]}, 32'd1);
    chk("midrst_done_valid", {31'd0, dv[1]}, 32'd0);
    chk("midrst_busy", {31'd0, busy[1]}, 32'd0);
    chk("midrst_product", prod[1], 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("midrst_still_idle", {31'd0, dv[1]}, 32'd0);
    do_mult(1, 8, 32'h03, 32'h05, p);
    chk("midrst_fresh_product", p, 32'h0000000F);

`ifdef MULT_DBG_EN
    start_op(1, 32'h02, 32'h03);
    chk("dbg_cnt0", {29'd0, c8}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      @(posedge Clk); #1;
      chk($sformatf("dbg_cnt%0d", i), {29'd0, c8}, i);
    end
    @(posedge Clk); #1;
    chk("dbg_done", {31'd0, dv[1]}, 32'd1);
    chk("dbg_bval", {24'd0, b8}, 32'h06);
    chk("dbg_aval", {24'd0, a8}, 32'h00);
    finish_op(1);
`endif

    // Random operands at WIDTH 4 and 16
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hF; rb = $urandom & 32'hF;
      do_mult(0, 4, ra, rb, p);
      chk("rand4_product", p, ref_mult(4, ra, rb));
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hFFFF; rb = $urandom & 32'hFFFF;
      if (i == 0) begin ra = 32'h8000; rb = 32'h8000; end
      do_mult(2, 16, ra, rb, p);
      chk("rand16_product", p, ref_mult(16, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
